stereo_ram_reader: RTL and testbench
====================================

// Module: stereo_ram_reader
// PURPOSE
//  Read-side engine for the two calc data RAMs that the camera capture writers fill.
//  On start, it walks both RAMs row by row and disparity by disparity.
//  It streams (f,g) pixel pairs with row/disparity tags to the matching engine over a valid/ready port.
//  It absorbs the 1-cycle RAM read latency and downstream backpressure, so no pair is dropped or duplicated.
// PARAMETERS
//  ADDR_W    11   RAM address width; requires LINE_LEN*ROWS <= 2**ADDR_W
//  DATA_W    3    pixel width of each RAM word
//  LINE_LEN  160  pixels per stored row
//  ROWS      12   rows stored per RAM
//  MAX_DISP  16   disparities scanned, 0..MAX_DISP-1; requires MAX_DISP < LINE_LEN
// PORTS
//  clk        in   1       single clock; RAM rdclock is driven from the same net
//  reset      in   1       asynchronous, active-high reset
//  start      in   1       1-cycle pulse; begins a full scan; ignored while busy=1
//  busy       out  1       high from the cycle after an accepted start until done
//  done       out  1       1-cycle pulse after the last pair is accepted downstream
//  rden       out  1       read enable shared by both RAMs
//  address_f  out  ADDR_W  read address, right/f RAM
//  address_g  out  ADDR_W  read address, left/g RAM
//  fdata      in   DATA_W  f RAM q; valid 1 clk after rden
//  gdata      in   DATA_W  g RAM q; valid 1 clk after rden
//  out_valid  out  1       pair available
//  out_ready  in   1       consumer accepts when out_valid & out_ready
//  out_f      out  DATA_W  f pixel
//  out_g      out  DATA_W  g pixel
//  out_row    out  4       row index, 0..ROWS-1 (width clog2(ROWS))
//  out_disp   out  6       disparity, 0..MAX_DISP-1
//  out_first  out  1       first pair of a (row,disp) pass
//  out_last   out  1       last pair of a (row,disp) pass
// BEHAVIOUR
//  - Reset: all outputs are 0, FSM=IDLE, FIFO empty, in-flight count=0. Reset mid-scan aborts the scan with no done pulse.
//  - FSM states and transitions:
//    - IDLE -> ISSUE on start.
//    - ISSUE -> DRAIN after the final read issues.
//    - DRAIN -> IDLE once the FIFO is empty and nothing is in flight; done pulses on that transition.
//  - Scan order: row r = 0..ROWS-1 (outer); disp d = 0..MAX_DISP-1; x = d..LINE_LEN-1 (inner).
//  - Addresses: address_f = r*LINE_LEN + x; address_g = r*LINE_LEN + x - d.
//    - The row base is kept in an accumulator (+LINE_LEN per row); no multiplier.
//  - Pass length: LINE_LEN - d beats. out_first is set at x=d; out_last is set at x=LINE_LEN-1.
//  - Tags (r, d, first, last) travel in a 1-deep shadow register alongside the read.
//    - They are written into the FIFO together with fdata/gdata.
//  - Output buffer: a 2-entry FIFO.
//    - A read issues (rden=1, addresses valid) only when occ + inflight - pop < 2, where pop = out_valid & out_ready.
//    - This guarantees no overflow. Sustained throughput is 1 pair/clk when out_ready is held at 1.
//  - out_* is driven from the FIFO head; out_valid = (occ != 0).
//    - Outputs hold stable while out_valid & ~out_ready.
//  - Simultaneous FIFO push and pop in the same cycle: occupancy is unchanged.
//  - rden=0 in IDLE and DRAIN, and in any ISSUE cycle without credit. Addresses hold their last value when rden=0.
//  - busy=1 in ISSUE and DRAIN. start is ignored in those states, including the cycle done pulses.
//  - Latency: with out_ready=1, start -> first out_valid is 3 clks (FSM, read, FIFO write).
//  - Total beats per scan = ROWS * sum over d of (LINE_LEN - d).
// TESTING
//  Test parameters: LINE_LEN=8, ROWS=2, MAX_DISP=3. RAM models have 1-clk latency and f[a]=a%8, g[a]=(a+1)%8.
//  1 Single scan, out_ready=1:
//    - 42 beats, then one done pulse.
//    - Beat 0: f=0, g=1, row=0, disp=0, first=1.
//    - Beat 8 (d=1, x=1): address_f=1, address_g=0, first=1.
//  2 Row-1 addressing:
//    - The first beat of row 1, d=2 has address_f=10, address_g=8, out_f=2, out_g=1.
//    - out_last=1 at address_f=15.
//  3 Backpressure: out_ready toggles 1010... then is held 0 for 20 clks mid-pass.
//    - The exact ordered sequence of 42 pairs is received, with no drop or duplicate.
//    - rden stays 0 while the FIFO is full.
//  4 start is pulsed again at beats 5 and 41.
//    - Both pulses are ignored; exactly one done is produced.
//    - A new start the cycle after done restarts at row 0, disp 0.
//  5 reset is asserted at beat 17, while a pair is in flight.
//    - All outputs go to 0 immediately and no done pulse occurs.
//    - A subsequent start produces a clean 42-beat scan.
//  6 Throughput, out_ready=1: rden is 1 on 42 consecutive clks; out_valid is 1 on 42 consecutive clks.

Source files
------------

// File: rtl/stereo_ram_reader.sv
// Read engine for the f/g calc RAMs: scans row, disparity, x and streams tagged (f,g) pairs.
// A credit check against a 2-entry output FIFO absorbs RAM latency and downstream backpressure.
module stereo_ram_reader #(
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 3,
  parameter int LINE_LEN = 160,
  parameter int ROWS     = 12,
  parameter int MAX_DISP = 16,
  localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rden,
  output logic [ADDR_W-1:0] address_f,
  output logic [ADDR_W-1:0] address_g,
  input  logic [DATA_W-1:0] fdata,
  input  logic [DATA_W-1:0] gdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_f,
  output logic [DATA_W-1:0] out_g,
  output logic [ROW_W-1:0]  out_row,
  output logic [5:0]        out_disp,
  output logic              out_first,
  output logic              out_last
);

  localparam int X_W    = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam int DISP_W = 6;
  localparam logic [X_W-1:0]    X_LAST   = X_W'(LINE_LEN - 1);
  localparam logic [DISP_W-1:0] D_LAST   = DISP_W'(MAX_DISP - 1);
  localparam logic [ROW_W-1:0]  R_LAST   = ROW_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(LINE_LEN);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  typedef struct packed {
    logic [ROW_W-1:0]  row;
    logic [DISP_W-1:0] disp;
    logic              first;
    logic              last;
  } tag_t;

  typedef struct packed {
    logic [DATA_W-1:0] f;
    logic [DATA_W-1:0] g;
    logic [ROW_W-1:0]  row;
    logic [DISP_W-1:0] disp;
    logic              first;
    logic              last;
  } beat_t;

  state_t            state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [DISP_W-1:0] disp_q, disp_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              done_q, done_d;
  tag_t              tag_q, tag_d;
  logic              tag_vld_q, tag_vld_d;
  beat_t             fifo_q [2];
  beat_t             fifo_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        occ_q, occ_d;

  logic              pop;
  logic              push;
  logic              credit;
  logic              issue;
  logic [ADDR_W-1:0] addr_f;
  beat_t             head;

  always_comb begin
    pop    = (occ_q != 2'd0) && out_ready;
    push   = tag_vld_q;
    // Entries already held plus the one still in the RAM pipe must leave room after this cycle's pop.
    credit = ({1'b0, occ_q} + {2'b00, tag_vld_q}) < (3'd2 + {2'b00, pop});
    issue  = (state_q == ISSUE) && credit;
    addr_f = base_q + ADDR_W'(x_q);

    state_d   = state_q;
    row_d     = row_q;
    disp_d    = disp_q;
    x_d       = x_q;
    base_d    = base_q;
    done_d    = 1'b0;
    tag_d     = tag_q;
    tag_vld_d = issue;

    case (state_q)
      IDLE: begin
        if (start && !done_q) begin
          state_d = ISSUE;
          row_d   = '0;
          disp_d  = '0;
          x_d     = '0;
          base_d  = '0;
        end
      end
      ISSUE: begin
        if (issue) begin
          tag_d = '{row: row_q, disp: disp_q,
                    first: (int'(x_q) == int'(disp_q)), last: (x_q == X_LAST)};
          if (x_q == X_LAST) begin
            if (disp_q == D_LAST) begin
              if (row_q == R_LAST) begin
                state_d = DRAIN;
              end else begin
                row_d  = row_q + ROW_W'(1);
                disp_d = '0;
                x_d    = '0;
                base_d = base_q + ROW_STEP;
              end
            end else begin
              disp_d = disp_q + DISP_W'(1);
              x_d    = X_W'(disp_q + DISP_W'(1));
            end
          end else begin
            x_d = x_q + X_W'(1);
          end
        end
      end
      DRAIN: begin
        if (occ_q == 2'd0 && !tag_vld_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) begin
      fifo_d[wr_ptr_q] = '{f: fdata, g: gdata, row: tag_q.row, disp: tag_q.disp,
                           first: tag_q.first, last: tag_q.last};
      wr_ptr_d = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      row_q     <= '0;
      disp_q    <= '0;
      x_q       <= '0;
      base_q    <= '0;
      done_q    <= 1'b0;
      tag_q     <= '0;
      tag_vld_q <= 1'b0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      occ_q     <= 2'd0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      disp_q    <= disp_d;
      x_q       <= x_d;
      base_q    <= base_d;
      done_q    <= done_d;
      tag_q     <= tag_d;
      tag_vld_q <= tag_vld_d;
      fifo_q    <= fifo_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
    end
  end

  assign head      = fifo_q[rd_ptr_q];
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign rden      = issue;
  assign address_f = addr_f;
  assign address_g = addr_f - ADDR_W'(disp_q);
  assign out_valid = (occ_q != 2'd0);
  assign out_f     = head.f;
  assign out_g     = head.g;
  assign out_row   = head.row;
  assign out_disp  = head.disp;
  assign out_first = head.first;
  assign out_last  = head.last;

endmodule

// File: tb/tb_stereo_ram_reader.sv
// Scoreboard bench for stereo_ram_reader: expected reads and beats are queued from a scan-order
// model, and a negedge monitor pops and compares them as the DUT issues reads and hands off pairs.
module tb_stereo_ram_reader;

  localparam int ADDR_W   = 11;
  localparam int DATA_W   = 3;
  localparam int LINE_LEN = 8;
  localparam int ROWS     = 2;
  localparam int MAX_DISP = 3;
  localparam int ROW_W    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int TOTAL    = ROWS * (MAX_DISP * LINE_LEN - (MAX_DISP * (MAX_DISP - 1)) / 2);

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              busy;
  logic              done;
  logic              rden;
  logic [ADDR_W-1:0] address_f;
  logic [ADDR_W-1:0] address_g;
  logic [DATA_W-1:0] fdata;
  logic [DATA_W-1:0] gdata;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_f;
  logic [DATA_W-1:0] out_g;
  logic [ROW_W-1:0]  out_row;
  logic [5:0]        out_disp;
  logic              out_first;
  logic              out_last;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_beats[$];
  int exp_af[$];
  int exp_ag[$];
  int outstanding = 0;
  int scan_pops = 0;
  int done_cnt = 0;
  int done_base = 0;
  int rden_run = 0, rden_max = 0, valid_run = 0, valid_max = 0;
  int start_cyc = 0, lat_meas = -1;
  bit lat_armed = 1'b0;
  bit hold_pending = 1'b0;
  int held_code = 0;
  int ready_mode = 0;
  int hold_zero = 0;

  stereo_ram_reader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_LEN(LINE_LEN), .ROWS(ROWS), .MAX_DISP(MAX_DISP)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .rden(rden),
    .address_f(address_f), .address_g(address_g), .fdata(fdata), .gdata(gdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_f(out_f), .out_g(out_g),
    .out_row(out_row), .out_disp(out_disp), .out_first(out_first), .out_last(out_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM models with one clock of read latency: f[a] = a%8, g[a] = (a+1)%8.
  always @(posedge clk) begin
    if (rden) begin
      fdata <= DATA_W'(int'(address_f) % 8);
      gdata <= DATA_W'((int'(address_g) + 1) % 8);
    end
  end

  function automatic int beatCode(input int f, input int g, input int row, input int disp,
                                  input int first, input int last);
    return f + 8 * g + 64 * row + 1024 * disp + 65536 * first + 131072 * last;
  endfunction

  function automatic int curCode();
    return beatCode(int'(out_f), int'(out_g), int'(out_row), int'(out_disp),
                    int'(out_first), int'(out_last));
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d (0x%0h) expected=%0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // Reference scan: every (row, disp, x) in order, with the addresses and RAM contents it implies.
  task automatic buildScan();
    for (int r = 0; r < ROWS; r++) begin
      for (int d = 0; d < MAX_DISP; d++) begin
        for (int x = d; x < LINE_LEN; x++) begin
          int af;
          int ag;
          af = r * LINE_LEN + x;
          ag = af - d;
          exp_af.push_back(af);
          exp_ag.push_back(ag);
          exp_beats.push_back(beatCode(af % 8, (ag + 1) % 8, r, d,
                                       (x == d) ? 1 : 0, (x == LINE_LEN - 1) ? 1 : 0));
        end
      end
    end
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    #1;
    buildScan();
    scan_pops = 0;
    rden_run = 0; rden_max = 0; valid_run = 0; valid_max = 0;
    done_base = done_cnt;
    lat_meas = -1;
    lat_armed = 1'b1;
    start_cyc = cyc;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic pulseStart();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic waitDone();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 3000);
    checkOutput("done_seen", int'(done), 1);
  endtask

  task automatic waitPops(input int target);
    int n;
    n = 0;
    while (scan_pops < target && n < 3000) begin
      @(posedge clk);
      n++;
    end
    checkOutput("reach_beat", (scan_pops >= target) ? 1 : 0, 1);
  endtask

  task automatic finishScan();
    repeat (4) @(negedge clk);
    checkOutput("done_count", done_cnt - done_base, 1);
    checkOutput("beat_count", scan_pops, TOTAL);
    checkOutput("beats_left", exp_beats.size(), 0);
    checkOutput("reads_left", exp_af.size(), 0);
    checkOutput("idle_busy", int'(busy), 0);
  endtask

  // Ready driver: forced-low window has priority, otherwise always-1, random or toggling.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (hold_zero > 0) begin
        out_ready = 1'b0;
        hold_zero--;
      end else begin
        case (ready_mode)
          0:       out_ready = 1'b1;
          1:       out_ready = ($urandom_range(0, 3) != 0);
          default: out_ready = ~out_ready;
        endcase
      end
    end
  end

  // Monitor: pops expected reads on rden and expected pairs on each handshake.
  always @(negedge clk) begin
    int pop;
    if (reset) begin
      outstanding = 0;
      hold_pending = 1'b0;
    end else begin
      pop = (out_valid && out_ready) ? 1 : 0;
      if (rden) begin
        checkOutput("read_credit", (outstanding - pop < 2) ? 1 : 0, 1);
        if (exp_af.size() == 0) begin
          checkOutput("unexpected_read", 1, 0);
        end else begin
          int ef;
          int eg;
          ef = exp_af.pop_front();
          eg = exp_ag.pop_front();
          checkOutput("address_f", int'(address_f), ef);
          checkOutput("address_g", int'(address_g), eg);
        end
        outstanding++;
        rden_run++;
        if (rden_run > rden_max) rden_max = rden_run;
      end else begin
        rden_run = 0;
      end
      if (hold_pending) begin
        checkOutput("hold_valid", int'(out_valid), 1);
        checkOutput("hold_data", curCode(), held_code);
      end
      if (out_valid) begin
        valid_run++;
        if (valid_run > valid_max) valid_max = valid_run;
        if (lat_armed) begin
          lat_meas = cyc - start_cyc;
          lat_armed = 1'b0;
        end
      end else begin
        valid_run = 0;
      end
      if (pop == 1) begin
        if (exp_beats.size() == 0) checkOutput("unexpected_beat", curCode(), -1);
        else checkOutput("beat", curCode(), exp_beats.pop_front());
        scan_pops++;
        outstanding--;
      end
      hold_pending = out_valid && !out_ready;
      held_code = curCode();
      if (done) done_cnt++;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b0;
    start = 1'b0;
    #1 reset = 1'b1;
    #1;
    checkOutput("reset_valid", int'(out_valid), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_rden", int'(rden), 0);
    checkOutput("reset_addr", int'(address_f) + int'(address_g), 0);
    checkOutput("reset_data", curCode(), 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    $display("[TB] single scan, out_ready held high");
    ready_mode = 0;
    applyStimulus();
    waitDone();
    finishScan();
    checkOutput("start_latency", lat_meas, 3);
    checkOutput("rden_run", rden_max, TOTAL);
    checkOutput("valid_run", valid_max, TOTAL);

    $display("[TB] toggling ready with a 20-cycle stall");
    ready_mode = 2;
    applyStimulus();
    fork
      waitDone();
      begin
        waitPops(10);
        hold_zero = 20;
      end
    join
    finishScan();

    $display("[TB] start pulses while busy and in the done cycle");
    ready_mode = 0;
    applyStimulus();
    fork
      waitDone();
      begin
        waitPops(5);
        pulseStart();
        waitPops(41);
        pulseStart();
      end
      begin
        int n;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!done && n < 3000);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
      end
    join
    finishScan();

    $display("[TB] restart the cycle after done, random ready");
    ready_mode = 1;
    applyStimulus();
    waitDone();
    applyStimulus();
    waitDone();
    finishScan();

    $display("[TB] reset mid-scan");
    ready_mode = 0;
    applyStimulus();
    waitPops(17);
    #2 reset = 1'b1;
    #1;
    checkOutput("abort_valid", int'(out_valid), 0);
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_rden", int'(rden), 0);
    checkOutput("abort_addr", int'(address_f) + int'(address_g), 0);
    checkOutput("abort_data", curCode(), 0);
    exp_beats.delete();
    exp_af.delete();
    exp_ag.delete();
    lat_armed = 1'b0;
    done_base = done_cnt;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("abort_no_done", done_cnt - done_base, 0);
    checkOutput("abort_idle", int'(busy), 0);
    applyStimulus();
    waitDone();
    finishScan();

    $display("[TB] random backpressure scan");
    ready_mode = 1;
    applyStimulus();
    waitDone();
    finishScan();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
